mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory word address width.
REQ-002 Parameter DATA_WIDTH, default 8, memory word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 Port clock  in  1  sole clock, rising-edge.
REQ-005 Port isReset  in  1  asynchronous, active-low reset.
REQ-006 Ports fetchReq/fetchAddr  in  1/ADDR_WIDTH  CPU instruction-fetch read request and address.
REQ-007 Ports dataReq/dataWe/dataAddr/dataWData  in  1/1/ADDR_WIDTH/DATA_WIDTH  CPU load/store request.
REQ-008 Ports loadReq/loadAddr/loadData  in  1/ADDR_WIDTH/DATA_WIDTH  program-loader write request.
REQ-009 Ports fetchGnt/dataGnt/loadGnt  out  1 each  request accepted this cycle.
REQ-010 Ports fetchRValid/dataRValid  out  1 each  rData belongs to that requester this cycle.
REQ-011 Port rData  out  DATA_WIDTH  registered copy of memRData for the read granted last cycle.
REQ-012 Ports memEn/memWe/memAddr/memWData  out  1/1/ADDR_WIDTH/DATA_WIDTH  single-port RAM command.
REQ-013 Port memRData  in  DATA_WIDTH  RAM read data, valid the cycle after memEn with memWe low.
REQ-014 Port cpuStall  out  1  high when fetchReq or dataReq is high and not granted.
REQ-015 Port loadCount  out  ADDR_WIDTH+1  loader writes accepted since entering LOAD.

Function
REQ-016 The state machine SHALL have states RUN and LOAD; at most one grant SHALL be high per cycle.
REQ-017 Grants and mem* outputs SHALL be combinational from current state and requests; memEn = OR of grants; mem* fields come from the granted requester; fetch grants drive memWe=0.
REQ-018 RUN, loadReq high: no grant, next state LOAD, loadCount cleared to 0.
REQ-019 RUN, loadReq low: dataGnt=dataReq unless starveCnt==STARVE_LIMIT and fetchReq is high, in which case fetchGnt=1 and dataGnt=0.
REQ-020 RUN, dataReq low: fetchGnt=fetchReq.
REQ-021 starveCnt SHALL increment (saturating at STARVE_LIMIT) each RUN cycle where fetchReq is high and fetchGnt low, clear on fetchGnt, and hold otherwise (including in LOAD).
REQ-022 LOAD, loadReq high: loadGnt=1, memWe=1, loadCount increments, saturating at all-ones.
REQ-023 LOAD, loadReq low: no grant, next state RUN; loadCount holds its final value.
REQ-024 Thus each RUN<->LOAD transition costs exactly one dead cycle with no grant.
REQ-025 A read granted in cycle N SHALL produce fetchRValid or dataRValid high for exactly cycle N+1 with rData=memRData; write grants produce no valid.
REQ-026 A read in flight SHALL complete normally across a RUN->LOAD transition.
REQ-027 Back-to-back reads SHALL sustain one grant per cycle with no bubbles.
REQ-028 cpuStall SHALL be asserted in every LOAD cycle and every transition cycle in which a CPU request is high.
REQ-029 Address/data inputs of non-granted requesters SHALL NOT affect mem* outputs.

Reset
REQ-030 isReset low SHALL immediately force state RUN, starveCnt 0, loadCount 0, fetchRValid 0, dataRValid 0, rData 0.
REQ-031 While isReset is low, all grants and memEn SHALL be 0 regardless of requests.
REQ-032 Reset asserted mid-read SHALL drop the pending valid; no valid is emitted after release.
REQ-033 After release, the first rising edge SHALL behave as RUN with cleared counters.

Verification
REQ-034 Reset with all requests high -> all grants, memEn, valids 0; after release, first cycle dataGnt=1.
REQ-035 fetchReq=1 fetchAddr=0x10; RAM[0x10]=0xA5 -> fetchGnt that cycle; next cycle fetchRValid=1, rData=0xA5.
REQ-036 dataReq and fetchReq held high, dataWe=0, STARVE_LIMIT=4 -> four dataGnt, then one fetchGnt, pattern repeats; cpuStall high on every denied cycle.
REQ-037 loadReq held 3 cycles (addr 0,1,2; data 0x11,0x22,0x33) during CPU traffic -> one dead cycle, 3 loadGnt writes, loadCount=3, one dead cycle, CPU grants resume; RAM reads back 0x11,0x22,0x33.
REQ-038 dataReq store (addr 0x05, data 0x7E) -> memEn=1, memWe=1, memAddr=0x05, memWData=0x7E, no dataRValid next cycle.
REQ-039 isReset pulsed low the cycle after a fetch grant -> fetchRValid stays 0; state RUN, loadCount 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-way arbiter in front of a single-port RAM: CPU fetch, CPU load/store and a
// program loader that owns the RAM exclusively while in LOAD. Reads return one cycle later.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  isReset,
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddr,
    input  logic                  dataReq,
    input  logic                  dataWe,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] dataWData,
    input  logic                  loadReq,
    input  logic [ADDR_WIDTH-1:0] loadAddr,
    input  logic [DATA_WIDTH-1:0] loadData,
    output logic                  fetchGnt,
    output logic                  dataGnt,
    output logic                  loadGnt,
    output logic                  fetchRValid,
    output logic                  dataRValid,
    output logic [DATA_WIDTH-1:0] rData,
    output logic                  memEn,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic                  cpuStall,
    output logic [ADDR_WIDTH:0]   loadCount
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RUN, LOAD} state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;

    assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        fetchGnt   = 1'b0;
        dataGnt    = 1'b0;
        loadGnt    = 1'b0;
        state_next = state;
        if (isReset) begin
            unique case (state)
                RUN: begin
                    if (loadReq)
                        state_next = LOAD;
                    else if (dataReq && !(starve_hit && fetchReq))
                        dataGnt = 1'b1;
                    else
                        fetchGnt = fetchReq;
                end
                LOAD: begin
                    if (loadReq)
                        loadGnt = 1'b1;
                    else
                        state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
    end

    // Only the granted requester steers the RAM command; idle cycles drive zeros.
    always_comb begin
        memEn    = fetchGnt | dataGnt | loadGnt;
        memWe    = loadGnt | (dataGnt & dataWe);
        memAddr  = '0;
        memWData = '0;
        if (fetchGnt) begin
            memAddr = fetchAddr;
        end else if (dataGnt) begin
            memAddr  = dataAddr;
            memWData = dataWData;
        end else if (loadGnt) begin
            memAddr  = loadAddr;
            memWData = loadData;
        end
    end

    assign cpuStall = (fetchReq & ~fetchGnt) | (dataReq & ~dataGnt);

    // memRData is already the RAM's registered output, so it is forwarded only while tagged valid.
    assign rData = (fetchRValid | dataRValid) ? memRData : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            state       <= RUN;
            starve_cnt  <= '0;
            loadCount   <= '0;
            fetchRValid <= 1'b0;
            dataRValid  <= 1'b0;
        end else begin
            state       <= state_next;
            fetchRValid <= fetchGnt;
            dataRValid  <= dataGnt & ~dataWe;

            if (state == RUN) begin
                if (fetchGnt)
                    starve_cnt <= '0;
                else if (fetchReq && !starve_hit)
                    starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == RUN && loadReq)
                loadCount <= '0;
            else if (loadGnt && loadCount != '1)
                loadCount <= loadCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous single-port RAM attached
// to the mem* command; expected values are hand-computed per scenario.
module tb_mem_arbiter;

    logic       clock;
    logic       isReset;
    logic       fetchReq, dataReq, dataWe, loadReq;
    logic [7:0] fetchAddr, dataAddr, dataWData, loadAddr, loadData;
    logic       fetchGnt, dataGnt, loadGnt, fetchRValid, dataRValid;
    logic [7:0] rData, memAddr, memWData, memRData;
    logic       memEn, memWe, cpuStall;
    logic [8:0] loadCount;

    logic       preset_en;
    logic [7:0] preset_addr, preset_data;
    logic [7:0] ram [256];

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
        .clock(clock), .isReset(isReset),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr),
        .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWData(dataWData),
        .loadReq(loadReq), .loadAddr(loadAddr), .loadData(loadData),
        .fetchGnt(fetchGnt), .dataGnt(dataGnt), .loadGnt(loadGnt),
        .fetchRValid(fetchRValid), .dataRValid(dataRValid), .rData(rData),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .cpuStall(cpuStall), .loadCount(loadCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (preset_en)
            ram[preset_addr] <= preset_data;
        else if (memEn) begin
            if (memWe) ram[memAddr] <= memWData;
            else       memRData     <= ram[memAddr];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preset(input logic [7:0] a, input logic [7:0] d);
        preset_en = 1'b1; preset_addr = a; preset_data = d;
        tick();
        preset_en = 1'b0;
    endtask

    task automatic apply_reset();
        isReset = 1'b0;
        fetchReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; loadReq = 1'b0;
        tick();
        tick();
        isReset = 1'b1;
    endtask

    task automatic test_reset();
        isReset = 1'b0;
        fetchReq = 1'b1; fetchAddr = 8'h10;
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = 8'h20;
        loadReq = 1'b1; loadAddr = 8'h01; loadData = 8'h55;
        #2;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn} !== 4'b0000) begin n_bad++; $display("FAIL reset_grants: got %b want 0000", {fetchGnt, dataGnt, loadGnt, memEn}); end
        n_cmp++; if ({fetchRValid, dataRValid, rData, loadCount} !== 19'd0) begin n_bad++; $display("FAIL reset_regs: got fv=%b dv=%b rData=%h lc=%0d want all 0", fetchRValid, dataRValid, rData, loadCount); end
        tick();
        loadReq = 1'b0;
        isReset = 1'b1;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn} !== 4'b0101) begin n_bad++; $display("FAIL reset_release_gnt: got %b want 0101", {fetchGnt, dataGnt, loadGnt, memEn}); end
        n_cmp++; if (memAddr !== 8'h20) begin n_bad++; $display("FAIL reset_release_addr: got %h want 20", memAddr); end
        tick();
        fetchReq = 1'b0; dataReq = 1'b0;
        n_cmp++; if ({dataRValid, rData} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL reset_release_read: got dv=%b rData=%h want 1/3c", dataRValid, rData); end
    endtask

    task automatic test_fetch_read();
        apply_reset();
        fetchReq = 1'b1; fetchAddr = 8'h10;
        dataAddr = 8'hFF; loadAddr = 8'hEE;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn, memWe} !== 5'b10010) begin n_bad++; $display("FAIL fetch_gnt: got %b want 10010", {fetchGnt, dataGnt, loadGnt, memEn, memWe}); end
        n_cmp++; if (memAddr !== 8'h10) begin n_bad++; $display("FAIL fetch_addr: got %h want 10", memAddr); end
        tick();
        fetchReq = 1'b0;
        n_cmp++; if ({fetchRValid, dataRValid, rData} !== {2'b10, 8'hA5}) begin n_bad++; $display("FAIL fetch_rvalid: got fv=%b dv=%b rData=%h want 1/0/a5", fetchRValid, dataRValid, rData); end
        tick();
        n_cmp++; if (fetchRValid !== 1'b0) begin n_bad++; $display("FAIL fetch_rvalid_once: got %b want 0", fetchRValid); end
    endtask

    task automatic test_starve();
        logic exp_f, prev_f;
        apply_reset();
        fetchReq = 1'b1; fetchAddr = 8'h10;
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = 8'h20;
        for (int i = 0; i < 10; i++) begin
            exp_f = (i % 5 == 4);
            #1;
            n_cmp++; if ({fetchGnt, dataGnt, cpuStall} !== {exp_f, ~exp_f, 1'b1}) begin n_bad++; $display("FAIL starve_gnt[%0d]: got f/d/stall=%b want %b", i, {fetchGnt, dataGnt, cpuStall}, {exp_f, ~exp_f, 1'b1}); end
            prev_f = exp_f;
            tick();
            n_cmp++; if ({fetchRValid, dataRValid, rData} !== {prev_f, ~prev_f, prev_f ? 8'hA5 : 8'h3C}) begin n_bad++; $display("FAIL starve_valid[%0d]: got fv=%b dv=%b rData=%h want fetch=%b", i, fetchRValid, dataRValid, rData, prev_f); end
        end
        fetchReq = 1'b0; dataReq = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] ld_data [3];
        ld_data[0] = 8'h11; ld_data[1] = 8'h22; ld_data[2] = 8'h33;
        apply_reset();
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = 8'h30;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn} !== 4'b0101) begin n_bad++; $display("FAIL load_pre_gnt: got %b want 0101", {fetchGnt, dataGnt, loadGnt, memEn}); end
        tick();
        loadReq = 1'b1; loadAddr = 8'h00; loadData = 8'h11;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn, cpuStall} !== 5'b00001) begin n_bad++; $display("FAIL load_dead_in: got %b want 00001", {fetchGnt, dataGnt, loadGnt, memEn, cpuStall}); end
        n_cmp++; if ({dataRValid, rData} !== {1'b1, 8'h5C}) begin n_bad++; $display("FAIL load_read_inflight: got dv=%b rData=%h want 1/5c", dataRValid, rData); end
        tick();
        for (int i = 0; i < 3; i++) begin
            loadAddr = 8'(i); loadData = ld_data[i];
            #1;
            n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn, memWe, cpuStall} !== 6'b001111) begin n_bad++; $display("FAIL load_gnt[%0d]: got %b want 001111", i, {fetchGnt, dataGnt, loadGnt, memEn, memWe, cpuStall}); end
            n_cmp++; if ({memAddr, memWData, loadCount} !== {8'(i), ld_data[i], 9'(i)}) begin n_bad++; $display("FAIL load_cmd[%0d]: got addr=%h wdata=%h lc=%0d want %h/%h/%0d", i, memAddr, memWData, loadCount, i, ld_data[i], i); end
            tick();
        end
        loadReq = 1'b0;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn, cpuStall} !== 5'b00001) begin n_bad++; $display("FAIL load_dead_out: got %b want 00001", {fetchGnt, dataGnt, loadGnt, memEn, cpuStall}); end
        n_cmp++; if (loadCount !== 9'd3) begin n_bad++; $display("FAIL load_count: got %0d want 3", loadCount); end
        tick();
        dataAddr = 8'h00;
        #1;
        n_cmp++; if ({dataGnt, cpuStall, loadCount} !== {2'b10, 9'd3}) begin n_bad++; $display("FAIL load_resume: got gnt=%b stall=%b lc=%0d want 1/0/3", dataGnt, cpuStall, loadCount); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) dataAddr = 8'(i + 1);
            else       dataReq  = 1'b0;
            n_cmp++; if ({dataRValid, rData} !== {1'b1, ld_data[i]}) begin n_bad++; $display("FAIL load_readback[%0d]: got dv=%b rData=%h want 1/%h", i, dataRValid, rData, ld_data[i]); end
        end
    endtask

    task automatic test_store();
        apply_reset();
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = 8'h05; dataWData = 8'h7E;
        fetchAddr = 8'hFF; loadAddr = 8'hEE; loadData = 8'h99;
        #1;
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn, memWe} !== 5'b01011) begin n_bad++; $display("FAIL store_gnt: got %b want 01011", {fetchGnt, dataGnt, loadGnt, memEn, memWe}); end
        n_cmp++; if ({memAddr, memWData} !== {8'h05, 8'h7E}) begin n_bad++; $display("FAIL store_cmd: got addr=%h wdata=%h want 05/7e", memAddr, memWData); end
        tick();
        dataReq = 1'b0; dataWe = 1'b0;
        n_cmp++; if ({fetchRValid, dataRValid} !== 2'b00) begin n_bad++; $display("FAIL store_no_valid: got %b want 00", {fetchRValid, dataRValid}); end
        fetchReq = 1'b1; fetchAddr = 8'h05;
        tick();
        fetchReq = 1'b0;
        n_cmp++; if ({fetchRValid, rData} !== {1'b1, 8'h7E}) begin n_bad++; $display("FAIL store_readback: got fv=%b rData=%h want 1/7e", fetchRValid, rData); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        loadReq = 1'b1; loadAddr = 8'h40; loadData = 8'h01;
        tick();
        tick();
        tick();
        loadReq = 1'b0;
        #1;
        n_cmp++; if (loadCount !== 9'd2) begin n_bad++; $display("FAIL rst_mid_precount: got %0d want 2", loadCount); end
        tick();
        fetchReq = 1'b1; fetchAddr = 8'h10;
        #1;
        n_cmp++; if (fetchGnt !== 1'b1) begin n_bad++; $display("FAIL rst_mid_fetch_gnt: got %b want 1", fetchGnt); end
        tick();
        isReset = 1'b0;
        dataReq = 1'b1; dataAddr = 8'h20;
        #1;
        n_cmp++; if ({fetchRValid, dataRValid, rData, loadCount} !== 19'd0) begin n_bad++; $display("FAIL rst_mid_cleared: got fv=%b dv=%b rData=%h lc=%0d want all 0", fetchRValid, dataRValid, rData, loadCount); end
        n_cmp++; if ({fetchGnt, dataGnt, loadGnt, memEn} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_grants: got %b want 0000", {fetchGnt, dataGnt, loadGnt, memEn}); end
        tick();
        isReset = 1'b1;
        fetchReq = 1'b0;
        #1;
        n_cmp++; if ({fetchRValid, dataGnt} !== 2'b01) begin n_bad++; $display("FAIL rst_mid_release: got fv=%b dgnt=%b want 0/1", fetchRValid, dataGnt); end
        tick();
        dataReq = 1'b0;
        n_cmp++; if ({fetchRValid, dataRValid, rData} !== {2'b01, 8'h3C}) begin n_bad++; $display("FAIL rst_mid_after: got fv=%b dv=%b rData=%h want 0/1/3c", fetchRValid, dataRValid, rData); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        isReset = 1'b0;
        fetchReq = 1'b0; dataReq = 1'b0; dataWe = 1'b0; loadReq = 1'b0;
        fetchAddr = 8'h00; dataAddr = 8'h00; dataWData = 8'h00;
        loadAddr = 8'h00; loadData = 8'h00;
        preset_en = 1'b0; preset_addr = 8'h00; preset_data = 8'h00;
        tick();
        preset(8'h10, 8'hA5);
        preset(8'h20, 8'h3C);
        preset(8'h30, 8'h5C);
        test_reset();
        test_fetch_read();
        test_starve();
        test_load();
        test_store();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
